// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, framing constants
// and the clocks-per-bit helper used by the TX and RX blocks.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_STOP_BITS = 1;

    // Clocks per bit, integer division of clock by baud rate.
    function automatic int uart_div(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_tx_8n1_if.sv
// Byte request / serial line bundle of the UART transmitter.
// master = requester, slave = transmitter.
interface uart_tx_8n1_if;

    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output tx_start,
        output tx_data,
        input  tx,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx,
        output tx_busy,
        output tx_done
    );

endinterface

// File: rtl/baud_tick_gen.sv
// Bit-period counter: counts 0..DIV-1 while enabled,
// held at zero otherwise, ticks on the last count.
module baud_tick_gen #(
    parameter int DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    if (DIV < 2) begin : g_div_chk
        $error("baud_tick_gen: DIV must be at least 2");
    end

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear when idle, wrap after the last count.
    always_comb begin
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_8n1.sv
// 8N1 UART transmitter: start bit, eight data bits LSB first,
// one stop bit, with registered line, busy and done outputs.
module uart_tx_8n1
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD_RATE = 9600
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_8n1_if.slave  bus
);

    localparam int DIV = uart_div(CLK_FREQ, BAUD_RATE);
    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    if (DIV < 2) begin : g_div_chk
        $error("uart_tx_8n1: CLK_FREQ/BAUD_RATE must be at least 2");
    end

    uart_state_e state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        tick;
    logic        en;

    assign en = (state_q != IDLE);

    baud_tick_gen #(
        .DIV (DIV)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .tick (tick)
    );

    // State, bit index and shift register update.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // Next state: a start request is only seen while idle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        unique case (state_q)
            IDLE: begin
                if (bus.tx_start) begin
                    shift_d = bus.tx_data;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the upcoming state so outputs are registered.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != IDLE);
        done_d = (state_q == STOP) && tick;
        unique case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    // Output registers; the line idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_q   <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            tx_q   <= tx_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign bus.tx      = tx_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;

endmodule
